// File: rtl/power_sequencer_pkg.sv
// Shared power-sequencer types: state and fault-code encodings.
// Also used by the power state monitor bench.
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        PS_ACTIVE      = 3'd0,
        PS_SAVING      = 3'd1,
        PS_ISOLATED    = 3'd2,
        PS_POWERED_OFF = 3'd3,
        PS_POWERING_ON = 3'd4,
        PS_RESTORING   = 3'd5
    } power_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_SAVE    = 2'd1,
        FC_PWRUP   = 2'd2,
        FC_RESTORE = 2'd3
    } fault_code_t;

    localparam logic [2:0] ST_ACTIVE      = 3'(PS_ACTIVE);
    localparam logic [2:0] ST_SAVING      = 3'(PS_SAVING);
    localparam logic [2:0] ST_ISOLATED    = 3'(PS_ISOLATED);
    localparam logic [2:0] ST_POWERED_OFF = 3'(PS_POWERED_OFF);
    localparam logic [2:0] ST_POWERING_ON = 3'(PS_POWERING_ON);
    localparam logic [2:0] ST_RESTORING   = 3'(PS_RESTORING);

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/power_sequencer_if.sv
// Request/handshake and status bundle of the power sequencer.
// slave = sequencer side, master = controller/bench side.
interface power_sequencer_if;
    import pwr_seq_pkg::*;

    logic       sleep_req;
    logic       wake_req;
    logic       save_done;
    logic       pwr_ack;
    logic       restore_done;
    logic       power_en;
    logic       iso_en;
    logic       save;
    logic       restore;
    logic [2:0] state;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output sleep_req, wake_req, save_done,
        output pwr_ack, restore_done,
        input  power_en, iso_en, save, restore,
        input  state, busy, fault, fault_code
    );

    modport slave (
        input  sleep_req, wake_req, save_done,
        input  pwr_ack, restore_done,
        output power_en, iso_en, save, restore,
        output state, busy, fault, fault_code
    );

endinterface

// File: rtl/power_seq_timer.sv
// Per-state dwell counter: clear on entry, saturating count,
// expiry when the count equals the supplied limit.
module power_seq_timer #(
    parameter int unsigned MAX = 16,
    parameter int unsigned W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != W'(MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/power_sequencer.sv
// Power-domain sequencer: save, isolate, power off, power on,
// restore, with handshake timeouts reported as fault codes.
module power_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned ISO_SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    power_sequencer_if.slave    bus
);

    localparam int unsigned CMAX = max_u(TIMEOUT, ISO_SETTLE);
    localparam int unsigned CW   = $clog2(CMAX + 1);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic          fault_q;
    logic          fault_d;
    logic [1:0]    code_q;
    logic [1:0]    code_d;
    logic [CW-1:0] limit;
    logic          expired;

    // Expiry fires in the last cycle of the allowed dwell.
    assign limit = (state_q == ST_ISOLATED) ? CW'(ISO_SETTLE - 1)
                                            : CW'(TIMEOUT - 1);

    power_seq_timer #(
        .MAX (CMAX),
        .W   (CW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_d != state_q),
        .en_i      (1'b1),
        .limit_i   (limit),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        fault_d = 1'b0;
        code_d  = code_q;
        case (state_q)
            ST_ACTIVE: begin
                if (bus.sleep_req && !bus.wake_req)
                    state_d = ST_SAVING;
            end
            ST_SAVING: begin
                if (bus.save_done) begin
                    state_d = ST_ISOLATED;
                end else if (expired) begin
                    state_d = ST_ACTIVE;
                    fault_d = 1'b1;
                    code_d  = FC_SAVE;
                end
            end
            ST_ISOLATED: begin
                if (expired)
                    state_d = ST_POWERED_OFF;
            end
            ST_POWERED_OFF: begin
                if (bus.wake_req)
                    state_d = ST_POWERING_ON;
            end
            ST_POWERING_ON: begin
                if (bus.pwr_ack) begin
                    state_d = ST_RESTORING;
                end else if (expired) begin
                    state_d = ST_POWERED_OFF;
                    fault_d = 1'b1;
                    code_d  = FC_PWRUP;
                end
            end
            ST_RESTORING: begin
                if (bus.restore_done) begin
                    state_d = ST_ACTIVE;
                end else if (expired) begin
                    state_d = ST_ACTIVE;
                    fault_d = 1'b1;
                    code_d  = FC_RESTORE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // Isolation covers every state where the rail may be down.
    assign bus.power_en   = (state_q != ST_POWERED_OFF);
    assign bus.iso_en     = (state_q == ST_ISOLATED)
                         || (state_q == ST_POWERED_OFF)
                         || (state_q == ST_POWERING_ON)
                         || (state_q == ST_RESTORING);
    assign bus.save       = (state_q == ST_SAVING);
    assign bus.restore    = (state_q == ST_RESTORING);
    assign bus.state      = state_q;
    assign bus.busy       = (state_q != ST_ACTIVE)
                         && (state_q != ST_POWERED_OFF);
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed and random checks of power_sequencer, two parameter sets.
// Isolation coverage is checked on every falling edge.
module tb_power_sequencer;
    import pwr_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic mon_on = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    power_sequencer_if a_if ();
    power_sequencer_if b_if ();

    power_sequencer #(.TIMEOUT(16), .ISO_SETTLE(2)) u_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if.slave)
    );

    power_sequencer #(.TIMEOUT(4), .ISO_SETTLE(2)) u_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] st,
                         input logic pe, input logic iso,
                         input logic flt, input logic [1:0] fc);
        chk({tag, ".st"}, a_if.state, st);
        chk({tag, ".pe"}, a_if.power_en, pe);
        chk({tag, ".iso"}, a_if.iso_en, iso);
        chk({tag, ".flt"}, a_if.fault, flt);
        chk({tag, ".fc"}, a_if.fault_code, fc);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("iso_a", a_if.iso_en | a_if.power_en, 1);
            chk("iso_b", b_if.iso_en | b_if.power_en, 1);
        end
    end

    task automatic a_to_off();
        a_if.sleep_req = 1'b1;
        step();
        a_if.sleep_req = 1'b0;
        a_if.save_done = 1'b1;
        step();
        a_if.save_done = 1'b0;
        step(2);
    endtask

    initial begin
        {a_if.sleep_req, a_if.wake_req, a_if.save_done} = '0;
        {a_if.pwr_ack, a_if.restore_done} = '0;
        {b_if.sleep_req, b_if.wake_req, b_if.save_done} = '0;
        {b_if.pwr_ack, b_if.restore_done} = '0;
        step(2);
        rst_a = 1'b0;
        rst_b = 1'b0;
        mon_on = 1'b1;
        chk_a("rst", 3'd0, 1, 0, 0, 2'd0);
        chk("rst.busy", a_if.busy, 0);
        chk("rst.save", a_if.save, 0);
        chk("rst_b.st", b_if.state, 0);

        // full sequence
        a_if.sleep_req = 1'b1;
        step();
        a_if.sleep_req = 1'b0;
        chk_a("sav", 3'd1, 1, 0, 0, 2'd0);
        chk("sav.save", a_if.save, 1);
        chk("sav.busy", a_if.busy, 1);
        a_if.restore_done = 1'b1;
        a_if.pwr_ack = 1'b1;
        step(2);
        a_if.restore_done = 1'b0;
        a_if.pwr_ack = 1'b0;
        chk("sav2.st", a_if.state, 1);
        a_if.save_done = 1'b1;
        step();
        a_if.save_done = 1'b0;
        chk_a("iso1", 3'd2, 1, 1, 0, 2'd0);
        a_if.wake_req = 1'b1;
        step();
        a_if.wake_req = 1'b0;
        chk("iso2.st", a_if.state, 2);
        step();
        chk_a("off", 3'd3, 0, 1, 0, 2'd0);
        chk("off.busy", a_if.busy, 0);
        a_if.sleep_req = 1'b1;
        step(2);
        a_if.sleep_req = 1'b0;
        chk("off2.st", a_if.state, 3);
        a_if.wake_req = 1'b1;
        step();
        a_if.wake_req = 1'b0;
        chk_a("pon", 3'd4, 1, 1, 0, 2'd0);
        step();
        a_if.pwr_ack = 1'b1;
        step();
        a_if.pwr_ack = 1'b0;
        chk_a("rest", 3'd5, 1, 1, 0, 2'd0);
        chk("rest.rs", a_if.restore, 1);
        step();
        a_if.restore_done = 1'b1;
        step();
        a_if.restore_done = 1'b0;
        chk_a("back", 3'd0, 1, 0, 0, 2'd0);
        chk("back.busy", a_if.busy, 0);

        // both requests together: stay active
        a_if.sleep_req = 1'b1;
        a_if.wake_req = 1'b1;
        step(2);
        a_if.sleep_req = 1'b0;
        a_if.wake_req = 1'b0;
        chk("both.st", a_if.state, 0);

        // power-up timeout, TIMEOUT=16
        a_to_off();
        chk("pto0.st", a_if.state, 3);
        a_if.wake_req = 1'b1;
        step();
        a_if.wake_req = 1'b0;
        step(15);
        chk_a("pto15", 3'd4, 1, 1, 0, 2'd0);
        step();
        chk_a("pto16", 3'd3, 0, 1, 1, 2'd2);
        step();
        chk_a("pto17", 3'd3, 0, 1, 0, 2'd2);
        a_if.wake_req = 1'b1;
        a_if.pwr_ack = 1'b1;
        step();
        a_if.wake_req = 1'b0;
        step();
        a_if.pwr_ack = 1'b0;
        chk("pre.st", a_if.state, 5);
        a_if.restore_done = 1'b1;
        step();
        a_if.restore_done = 1'b0;
        chk_a("prec", 3'd0, 1, 0, 0, 2'd2);

        // reset in POWERED_OFF
        a_to_off();
        chk("roff0.st", a_if.state, 3);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk_a("roff", 3'd0, 1, 0, 0, 2'd0);
        chk("roff.busy", a_if.busy, 0);

        // restore timeout, then reset in RESTORING
        a_to_off();
        a_if.wake_req = 1'b1;
        a_if.pwr_ack = 1'b1;
        step(2);
        a_if.wake_req = 1'b0;
        a_if.pwr_ack = 1'b0;
        step(16);
        chk_a("rto", 3'd0, 1, 0, 1, 2'd3);
        a_to_off();
        a_if.wake_req = 1'b1;
        a_if.pwr_ack = 1'b1;
        step(2);
        a_if.wake_req = 1'b0;
        a_if.pwr_ack = 1'b0;
        chk("rres0.st", a_if.state, 5);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk_a("rres", 3'd0, 1, 0, 0, 2'd0);
        chk("rres.rs", a_if.restore, 0);

        // save timeout, TIMEOUT=4
        b_if.sleep_req = 1'b1;
        step();
        b_if.sleep_req = 1'b0;
        step(3);
        chk("sto3.st", b_if.state, 1);
        chk("sto3.pe", b_if.power_en, 1);
        step();
        chk("sto4.st", b_if.state, 0);
        chk("sto4.flt", b_if.fault, 1);
        chk("sto4.fc", b_if.fault_code, 1);
        step();
        chk("sto5.flt", b_if.fault, 0);
        chk("sto5.fc", b_if.fault_code, 1);

        // save_done on the expiry edge wins
        b_if.sleep_req = 1'b1;
        step();
        b_if.sleep_req = 1'b0;
        step(3);
        b_if.save_done = 1'b1;
        step();
        b_if.save_done = 1'b0;
        chk("coin.st", b_if.state, 2);
        chk("coin.flt", b_if.fault, 0);
        chk("coin.fc", b_if.fault_code, 1);
        step(2);
        chk("coin2.st", b_if.state, 3);

        // random request/ack soak
        for (int i = 0; i < 10000; i++) begin
            a_if.sleep_req    = ($urandom_range(0, 3) == 0);
            a_if.wake_req     = ($urandom_range(0, 3) == 0);
            a_if.save_done    = ($urandom_range(0, 7) == 0);
            a_if.pwr_ack      = ($urandom_range(0, 9) == 0);
            a_if.restore_done = ($urandom_range(0, 7) == 0);
            b_if.sleep_req    = a_if.wake_req;
            b_if.wake_req     = a_if.sleep_req;
            b_if.save_done    = ($urandom_range(0, 5) == 0);
            b_if.pwr_ack      = ($urandom_range(0, 5) == 0);
            b_if.restore_done = ($urandom_range(0, 5) == 0);
            rst_a = ($urandom_range(0, 499) == 0);
            step();
        end
        rst_a = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
